// File: rtl/clk_div_sched_if.sv
// Request/response bundle between the two divisor-change requesters and clk_div_sched,
// plus the divider-facing outputs (reset, divisor) and status.
interface clk_div_sched_if #(
  parameter int DW = 16
);
  logic          i_req0_valid;
  logic [DW-1:0] i_req0_divisor;
  logic          o_req0_ready;
  logic          i_req1_valid;
  logic [DW-1:0] i_req1_divisor;
  logic          o_req1_ready;
  logic          o_div_rst;
  logic [DW-1:0] o_divisor;
  logic          o_grant_id;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_req0_valid, i_req0_divisor, i_req1_valid, i_req1_divisor,
    input  o_req0_ready, o_req1_ready, o_div_rst, o_divisor, o_grant_id, o_busy, o_done
  );

  modport slave (
    input  i_req0_valid, i_req0_divisor, i_req1_valid, i_req1_divisor,
    output o_req0_ready, o_req1_ready, o_div_rst, o_divisor, o_grant_id, o_busy, o_done
  );
endinterface

// File: rtl/clk_div_sched.sv
// Round-robin divisor-change sequencer: done SETTLE_CYC+LOCK_CYC cycles after the ready pulse
// (no-op: next cycle); requests wait, valid held, until the FSM is IDLE.
module clk_div_sched #(
  parameter int            DW         = 16,
  parameter logic [DW-1:0] DEF_DIV    = '0,
  parameter int            SETTLE_CYC = 4,
  parameter int            LOCK_CYC   = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  clk_div_sched_if.slave bus
);

  localparam int MAXC = (SETTLE_CYC > LOCK_CYC) ? SETTLE_CYC : LOCK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN_WAIT, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_noop;
  logic          r_grant;
  logic [DW-1:0] r_divisor;
  logic          r_rdy0, r_rdy1;
  logic          r_div_rst, r_busy, r_done;

  logic          w_win;
  logic [DW-1:0] w_win_div;
  logic          w_accept;
  logic          w_change;

  always_comb begin
    w_state_nxt = r_state;
    w_win       = (bus.i_req0_valid & bus.i_req1_valid) ? ~r_last : bus.i_req1_valid;
    w_win_div   = w_win ? bus.i_req1_divisor : bus.i_req0_divisor;
    // A no-op acceptance spends its ready cycle in IDLE; r_noop blocks re-arbitration there.
    w_accept    = (r_state == IDLE) && !r_noop && (bus.i_req0_valid || bus.i_req1_valid);
    w_change    = (w_win_div != r_divisor);
    case (r_state)
      IDLE: begin
        if (r_noop)
          w_state_nxt = DONE;
        else if (w_accept && w_change)
          w_state_nxt = HOLD;
      end
      HOLD:     if (r_cnt == SETTLE_LAST) w_state_nxt = RUN_WAIT;
      RUN_WAIT: if (r_cnt == LOCK_LAST)   w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_noop    <= 1'b0;
      r_grant   <= 1'b0;
      r_divisor <= DEF_DIV;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
      r_div_rst <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || r_state == IDLE || r_state == DONE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      r_noop <= w_accept && !w_change;
      r_rdy0 <= w_accept && !w_win;
      r_rdy1 <= w_accept && w_win;
      if (w_accept) begin
        r_grant <= w_win;
        r_last  <= w_win;
        if (w_change)
          r_divisor <= w_win_div;
      end
      // Outputs decoded from the next state and registered so the divider reset never glitches.
      r_div_rst <= (w_state_nxt != HOLD);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign bus.o_req0_ready = r_rdy0;
  assign bus.o_req1_ready = r_rdy1;
  assign bus.o_div_rst    = r_div_rst;
  assign bus.o_divisor    = r_divisor;
  assign bus.o_grant_id   = r_grant;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scenario bench for clk_div_sched: accepted requests are scoreboarded, and each change's
// reset/done/busy timing is profiled cycle by cycle on the falling edge.
module tb_clk_div_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  clk_div_sched_if #(.DW(16)) bus ();

  clk_div_sched #(.DW(16), .DEF_DIV(16'd0), .SETTLE_CYC(4), .LOCK_CYC(8)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] div;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.o_req0_ready || bus.o_req1_ready) begin
        n = i;
        break;
      end
    end
  endtask

  // Cycle 0 is the current falling edge; stops at the first non-busy cycle after cycle 0.
  task automatic profile(output int low, output int done_at, output int idle_at,
                         output int dones, output int rdys);
    low = 0; done_at = -1; idle_at = -1; dones = 0; rdys = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if (!bus.o_div_rst) low++;
      if (bus.o_req0_ready || bus.o_req1_ready) rdys++;
      if (bus.o_done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (c > 0 && !bus.o_busy) begin
        idle_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int low, done_at, idle_at, dones, rdys;
    bus.i_req0_valid = 1'b0; bus.i_req0_divisor = '0;
    bus.i_req1_valid = 1'b0; bus.i_req1_divisor = '0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_div_rst !== 1'b0) begin errors++; $display("FAIL reset_div_rst got=%b want=0", bus.o_div_rst); end
    checks++; if (bus.o_divisor !== 16'd0) begin errors++; $display("FAIL reset_divisor got=%0d want=0", bus.o_divisor); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", bus.o_busy); end
    checks++; if ({bus.o_done, bus.o_req0_ready, bus.o_req1_ready, bus.o_grant_id} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got=%b want=0000", {bus.o_done, bus.o_req0_ready, bus.o_req1_ready, bus.o_grant_id}); end
    @(negedge clk);
    rst_n = 1'b1;
    profile(low, done_at, idle_at, dones, rdys);
    checks++; if (low !== 4) begin errors++; $display("FAIL pwrup_hold got=%0d want=4", low); end
    checks++; if (done_at !== 12 || dones !== 1) begin errors++; $display("FAIL pwrup_done got=%0d/%0d want=12/1", done_at, dones); end
    checks++; if (idle_at !== 13) begin errors++; $display("FAIL pwrup_idle got=%0d want=13", idle_at); end
    checks++; if (bus.o_divisor !== 16'd0) begin errors++; $display("FAIL pwrup_divisor got=%0d want=0", bus.o_divisor); end
  endtask

  task automatic test_single_change;
    int n, low, done_at, idle_at, dones, rdys;
    sb.push_back('{id: 1'b0, div: 16'd5});
    bus.i_req0_divisor = 16'd5; bus.i_req0_valid = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL single_ready_latency got=%0d want=0", n);
    end
    if (n >= 0) begin
      e = sb.pop_front();
      checks++; if (bus.o_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%b want=1", bus.o_req0_ready); end
      checks++; if (bus.o_grant_id !== e.id || bus.o_divisor !== e.div) begin
        errors++; $display("FAIL single_grant got=%b/%0d want=%b/%0d", bus.o_grant_id, bus.o_divisor, e.id, e.div); end
      bus.i_req0_valid = 1'b0;
      profile(low, done_at, idle_at, dones, rdys);
      checks++; if (low !== 4) begin errors++; $display("FAIL single_hold got=%0d want=4", low); end
      checks++; if (done_at !== 12 || dones !== 1) begin errors++; $display("FAIL single_done got=%0d/%0d want=12/1", done_at, dones); end
      checks++; if (idle_at !== 13 || rdys !== 1) begin errors++; $display("FAIL single_idle_rdy got=%0d/%0d want=13/1", idle_at, rdys); end
    end
  endtask

  task automatic test_noop;
    int n, low, done_at, idle_at, dones, rdys;
    sb.push_back('{id: 1'b1, div: 16'd5});
    bus.i_req1_divisor = 16'd5; bus.i_req1_valid = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL noop_ready_latency got=%0d want=0", n);
    end
    if (n >= 0) begin
      e = sb.pop_front();
      checks++; if (bus.o_req1_ready !== 1'b1 || bus.o_grant_id !== e.id || bus.o_divisor !== e.div) begin
        errors++; $display("FAIL noop_grant got=%b/%b/%0d want=1/%b/%0d", bus.o_req1_ready, bus.o_grant_id, bus.o_divisor, e.id, e.div); end
      bus.i_req1_valid = 1'b0;
      profile(low, done_at, idle_at, dones, rdys);
      checks++; if (low !== 0) begin errors++; $display("FAIL noop_div_rst_low got=%0d want=0", low); end
      checks++; if (done_at !== 1 || dones !== 1) begin errors++; $display("FAIL noop_done got=%0d/%0d want=1/1", done_at, dones); end
      checks++; if (idle_at !== 2) begin errors++; $display("FAIL noop_busy got=%0d want=2", idle_at); end
    end
  endtask

  task automatic test_contention;
    int n, low, done_at, idle_at, dones, rdys;
    sb.push_back('{id: 1'b0, div: 16'd3});
    sb.push_back('{id: 1'b1, div: 16'd7});
    bus.i_req0_divisor = 16'd3; bus.i_req0_valid = 1'b1;
    bus.i_req1_divisor = 16'd7; bus.i_req1_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ready(n);
      checks++;
      if (n !== 0) begin
        errors++; $display("FAIL contend%0d_ready_latency got=%0d want=0", k, n);
      end
      if (n >= 0) begin
        e = sb.pop_front();
        checks++; if (bus.o_grant_id !== e.id || bus.o_divisor !== e.div) begin
          errors++; $display("FAIL contend%0d_grant got=%b/%0d want=%b/%0d", k, bus.o_grant_id, bus.o_divisor, e.id, e.div); end
        if (bus.o_req0_ready) bus.i_req0_valid = 1'b0;
        if (bus.o_req1_ready) bus.i_req1_valid = 1'b0;
        profile(low, done_at, idle_at, dones, rdys);
        checks++; if (done_at !== 12 || idle_at !== 13) begin
          errors++; $display("FAIL contend%0d_timing got=%0d/%0d want=12/13", k, done_at, idle_at); end
      end
    end
  endtask

  task automatic test_req_while_busy;
    int n, done_c, rdy_c, low, done_at, idle_at, dones, rdys;
    bit early;
    sb.push_back('{id: 1'b0, div: 16'd2});
    bus.i_req0_divisor = 16'd2; bus.i_req0_valid = 1'b1;
    wait_ready(n);
    checks++;
    if (n < 0) begin
      errors++; $display("FAIL busy_first_ready got=timeout want=0");
    end else begin
      e = sb.pop_front();
      bus.i_req0_valid = 1'b0;
      @(negedge clk);
      sb.push_back('{id: 1'b1, div: 16'd4});
      bus.i_req1_divisor = 16'd4; bus.i_req1_valid = 1'b1;
      done_c = -1; rdy_c = -1; early = 1'b0;
      for (int c = 1; c < 64; c++) begin
        if (c > 1) @(negedge clk);
        if (bus.o_done) done_c = c;
        if (bus.o_req1_ready) begin
          if (done_c < 0) early = 1'b1;
          rdy_c = c;
          break;
        end
      end
      checks++; if (early !== 1'b0 || done_c !== 12) begin errors++; $display("FAIL busy_blocked got=early%b/done%0d want=early0/done12", early, done_c); end
      checks++; if (rdy_c !== 14) begin errors++; $display("FAIL busy_accept_cycle got=%0d want=14", rdy_c); end
      e = sb.pop_front();
      checks++; if (bus.o_grant_id !== e.id || bus.o_divisor !== e.div) begin
        errors++; $display("FAIL busy_grant got=%b/%0d want=%b/%0d", bus.o_grant_id, bus.o_divisor, e.id, e.div); end
      bus.i_req1_valid = 1'b0;
      profile(low, done_at, idle_at, dones, rdys);
      checks++; if (low !== 4 || done_at !== 12) begin errors++; $display("FAIL busy_second_timing got=%0d/%0d want=4/12", low, done_at); end
    end
  endtask

  task automatic test_reset_mid;
    int n, low, done_at, idle_at, dones, rdys, rst_dones;
    sb.push_back('{id: 1'b0, div: 16'd9});
    bus.i_req0_divisor = 16'd9; bus.i_req0_valid = 1'b1;
    wait_ready(n);
    checks++;
    if (n < 0) begin
      errors++; $display("FAIL rstmid_ready got=timeout want=0");
    end else begin
      e = sb.pop_front();
      bus.i_req0_valid = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (bus.o_div_rst !== 1'b1 || bus.o_divisor !== e.div) begin
        errors++; $display("FAIL rstmid_run_wait got=%b/%0d want=1/%0d", bus.o_div_rst, bus.o_divisor, e.div); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.o_div_rst !== 1'b0 || bus.o_divisor !== 16'd0 || bus.o_busy !== 1'b1) begin
        errors++; $display("FAIL rstmid_async got=%b/%0d/%b want=0/0/1", bus.o_div_rst, bus.o_divisor, bus.o_busy); end
      rst_dones = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.o_done) rst_dones++;
      end
      checks++; if (rst_dones !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", rst_dones); end
      rst_n = 1'b1;
      profile(low, done_at, idle_at, dones, rdys);
      checks++; if (low !== 4 || done_at !== 12 || dones !== 1 || idle_at !== 13) begin
        errors++; $display("FAIL rstmid_pwrup got=%0d/%0d/%0d/%0d want=4/12/1/13", low, done_at, dones, idle_at); end
      checks++; if (bus.o_divisor !== 16'd0) begin errors++; $display("FAIL rstmid_divisor got=%0d want=0", bus.o_divisor); end
    end
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_noop();
    test_contention();
    test_req_while_busy();
    test_reset_mid();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
